// File: rtl/phy_tx_pkg.sv
// Shared PHY TX definitions: serialiser mode encodings and lane-index width helper.
// No logic, no latency, no flow control.
package phy_tx_pkg;

  localparam int MUX_MODE_TDM = 0;
  localparam int MUX_MODE_RR  = 1;

  // Lane index width; a 2-lane mux still needs one bit.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set req bit at or after ptr, wrapping, purely combinational.
// Zero latency; no backpressure (found low when req is empty).
module rr_pick
  import phy_tx_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = lane_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic          found,
  output logic [LW-1:0] grant
);

  localparam logic [2*N-1:0] ONE = (2*N)'(1);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] below;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // The upper copy of req catches requests that wrap past lane N-1.
  assign req_dbl = {req, req};
  assign below   = (ONE << ptr) - ONE;
  assign masked  = req_dbl & ~below;
  assign first   = masked & (~masked + ONE);
  assign found   = |req;

  always_comb begin
    grant = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (first[i]) grant = grant | LW'(i % N);
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-to-1 lane serialiser, TDM fixed slots (MODE 0) or skip-idle round-robin (MODE 1).
// 1-cycle registered latency; no backpressure, unserved lane words are dropped.
module mux_nx1_rr
  import phy_tx_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = MUX_MODE_TDM,
  localparam int LW    = lane_w(N)
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [N-1:0]       valid_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               valid_out,
  output logic [LW-1:0]      lane_out,
  output logic               frame_start
);

  localparam logic [LW-1:0] LAST = LW'(N - 1);

  logic [LW-1:0]    ptr;
  logic [LW-1:0]    ptr_nxt;
  logic [LW-1:0]    sel;
  logic             take;
  logic             lane_upd;
  logic             fs_nxt;
  logic [WIDTH-1:0] lanes [N];

  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lanes[k] = data_in[k*WIDTH +: WIDTH];
  end

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic          found;
    logic [LW-1:0] grant;

    rr_pick #(.N(N), .LW(LW)) u_pick (
      .req   (valid_in),
      .ptr   (ptr),
      .found (found),
      .grant (grant)
    );

    // Idle cycles leave pointer and lane index parked on the last grant.
    assign sel      = grant;
    assign take     = found;
    assign lane_upd = found;
    assign fs_nxt   = 1'b0;
    assign ptr_nxt  = found ? wrap_inc(grant) : ptr;
  end else begin : g_tdm
    // The slot is consumed whether or not its lane is valid.
    assign sel      = ptr;
    assign take     = valid_in[ptr];
    assign lane_upd = 1'b1;
    assign fs_nxt   = (ptr == '0);
    assign ptr_nxt  = wrap_inc(ptr);
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= '0;
      frame_start <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      valid_out   <= take;
      frame_start <= fs_nxt;
      if (take)     data_out <= lanes[sel];
      if (lane_upd) lane_out <= sel;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: four parameterisations share one stimulus, a behavioural model
// queues the expected output per cycle and the active instance is compared one cycle later.
module tb_mux_nx1_rr;

  typedef struct packed {
    logic [15:0] pk;
    logic [4:0]  v;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] vin;
  logic [9:0] din [5];
  int         sel_dut;

  logic [7:0] o0_dat, o1_dat, o2_dat;
  logic [9:0] o3_dat;
  logic       o0_vld, o1_vld, o2_vld, o3_vld;
  logic [1:0] o0_lane, o1_lane, o2_lane;
  logic [2:0] o3_lane;
  logic       o0_fs, o1_fs, o2_fs, o3_fs;
  logic [15:0] obs;

  always #5 clk = ~clk;

  mux_nx1_rr #(.WIDTH(8), .N(4), .MODE(0)) u_tdm4 (
    .clk_4f(clk), .reset(reset),
    .data_in({din[3][7:0], din[2][7:0], din[1][7:0], din[0][7:0]}), .valid_in(vin[3:0]),
    .data_out(o0_dat), .valid_out(o0_vld), .lane_out(o0_lane), .frame_start(o0_fs));

  mux_nx1_rr #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
    .clk_4f(clk), .reset(reset),
    .data_in({din[3][7:0], din[2][7:0], din[1][7:0], din[0][7:0]}), .valid_in(vin[3:0]),
    .data_out(o1_dat), .valid_out(o1_vld), .lane_out(o1_lane), .frame_start(o1_fs));

  mux_nx1_rr #(.WIDTH(8), .N(3), .MODE(0)) u_tdm3 (
    .clk_4f(clk), .reset(reset),
    .data_in({din[2][7:0], din[1][7:0], din[0][7:0]}), .valid_in(vin[2:0]),
    .data_out(o2_dat), .valid_out(o2_vld), .lane_out(o2_lane), .frame_start(o2_fs));

  mux_nx1_rr #(.WIDTH(10), .N(5), .MODE(1)) u_rr5 (
    .clk_4f(clk), .reset(reset),
    .data_in({din[4], din[3], din[2], din[1], din[0]}), .valid_in(vin),
    .data_out(o3_dat), .valid_out(o3_vld), .lane_out(o3_lane), .frame_start(o3_fs));

  // Observed tuple {frame_start, lane[3:0], valid, data[9:0]} of the instance under test.
  always_comb begin
    obs = '0;
    case (sel_dut)
      0:       obs = {o0_fs, 2'b00, o0_lane, o0_vld, 2'b00, o0_dat};
      1:       obs = {o1_fs, 2'b00, o1_lane, o1_vld, 2'b00, o1_dat};
      2:       obs = {o2_fs, 2'b00, o2_lane, o2_vld, 2'b00, o2_dat};
      default: obs = {o3_fs, 1'b0, o3_lane, o3_vld, o3_dat};
    endcase
  end

  int    n_chk = 0;
  int    n_fail = 0;
  string cur_tag;
  sb_t   q[$];

  int         m_n, m_mode, m_w, m_ptr, m_lane;
  logic [9:0] m_dat;
  int         wait_cnt [5];
  int         max_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: asserts reset between edges, checks it clears at once,
  // and releases it on the next falling edge with the model restarted.
  task automatic do_reset(input int dsel, input int n, input int mode, input int w);
    reset = 1'b1;
    sel_dut = dsel;
    m_n = n; m_mode = mode; m_w = w;
    m_ptr = 0; m_lane = 0; m_dat = '0;
    q.delete();
    #1;
    chk("reset_clear", obs, 16'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge: drives one input pattern, queues the model result,
  // compares after the next rising edge, returns on the following falling edge.
  task automatic cyc(input logic [4:0] v);
    logic [9:0]  mask;
    logic [15:0] e;
    logic        e_vld, e_fs;
    int          e_lane, g, idx;
    sb_t         ent;
    vin  = v;
    mask = (m_w == 8) ? 10'h0FF : 10'h3FF;
    if (m_mode == 0) begin
      e_lane = m_ptr;
      e_fs   = (m_ptr == 0);
      e_vld  = v[m_ptr];
      if (e_vld) m_dat = din[m_ptr] & mask;
      m_ptr = (m_ptr + 1) % m_n;
    end else begin
      g = -1;
      for (int k = 0; k < m_n; k++) begin
        idx = (m_ptr + k) % m_n;
        if (g < 0 && v[idx]) g = idx;
      end
      e_fs  = 1'b0;
      e_vld = (g >= 0);
      if (e_vld) begin
        m_dat  = din[g] & mask;
        m_lane = g;
        m_ptr  = (g + 1) % m_n;
      end
      e_lane = m_lane;
    end
    e = {e_fs, 4'(e_lane), e_vld, m_dat};
    q.push_back({e, v});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      ent = q.pop_front();
      chk(cur_tag, obs, ent.pk);
      if (sel_dut == 3) begin
        for (int k = 0; k < 5; k++) begin
          if (o3_vld && o3_lane == 3'(k)) wait_cnt[k] = 0;
          else if (ent.v[k])              wait_cnt[k]++;
          else                            wait_cnt[k] = 0;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vin = '0;
    for (int k = 0; k < 5; k++) din[k] = 10'(8'hA0 + k);
    do_reset(0, 4, 0, 8);

    cur_tag = "tdm4_all_valid";
    cyc(5'b01111);
    chk("tdm4_first_word", {o0_fs, o0_vld, o0_lane, o0_dat}, {1'b1, 1'b1, 2'd0, 8'hA0});
    repeat (4) cyc(5'b01111);
    cur_tag = "tdm4_lane2_idle";
    repeat (4) cyc(5'b01011);

    do_reset(1, 4, 1, 8);
    din[1] = 10'h011;
    din[3] = 10'h033;
    cur_tag = "rr4_alternate";
    repeat (6) cyc(5'b01010);
    cur_tag = "rr4_idle";
    repeat (3) cyc(5'b00000);
    cur_tag = "rr4_resume";
    cyc(5'b00001);
    cyc(5'b01001);
    cyc(5'b01001);

    do_reset(2, 3, 0, 8);
    for (int k = 0; k < 3; k++) din[k] = 10'(8'hA0 + k);
    cur_tag = "tdm3_wrap";
    repeat (7) cyc(5'b00111);
    do_reset(2, 3, 0, 8);
    cur_tag = "tdm3_after_reset";
    repeat (4) cyc(5'b00111);

    do_reset(3, 5, 1, 10);
    for (int k = 0; k < 5; k++) wait_cnt[k] = 0;
    max_wait = 0;
    cur_tag = "rr5_random";
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 5; k++) din[k] = 10'($urandom);
      cyc(5'($urandom));
    end
    chk("rr5_no_starvation", 32'(max_wait <= 4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 byte serialiser for the PHY TX path. It merges N lanes, each with a data bus and a valid, onto one registered output stream at the `clk_4f` rate. Two modes are available: fixed time-division slots, or work-conserving round-robin that skips idle lanes. It generalises the fixed 2:1 valid-qualified mux stage and sits between the lane buffers and the serial/parallel converter.

## Interface
Parameters:
- `WIDTH`, 8: bits per lane and per output word.
- `N`, 4: number of input lanes; legal range 2..16, need not be a power of 2.
- `MODE`, 0: 0 = TDM fixed slots, 1 = round-robin skip-idle.

Ports:
- `clk_4f`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset (already decided).
- `data_in`, input, N*WIDTH: flattened lanes; lane k occupies bits [k*WIDTH +: WIDTH].
- `valid_in`, input, N: bit k qualifies lane k in the current cycle.
- `data_out`, output, WIDTH: registered selected word.
- `valid_out`, output, 1: registered; high when `data_out` carries a new word this cycle.
- `lane_out`, output, LW: registered index of the lane that was sampled; LW = max(1, clog2(N)).
- `frame_start`, output, 1: registered; in MODE 0, high on the output cycle of the lane-0 slot; tied 0 in MODE 1.

## Operation
- State: slot pointer `ptr` (LW bits, range 0..N-1) plus the output registers.
- Wrap rule: after N-1 the pointer returns to 0; it never reaches values of N or above.
- MODE 0 (TDM), every cycle:
  - `lane_out` <= `ptr`.
  - `frame_start` <= (`ptr` == 0).
  - If `valid_in[ptr]`: `data_out` <= lane `ptr`, `valid_out` <= 1.
  - Otherwise: `data_out` holds its previous value and `valid_out` <= 0; the slot is consumed anyway.
  - `ptr` <= `ptr`+1 with wrap.
- MODE 1 (RR), every cycle:
  - `grant` = first k with `valid_in[k]` = 1, searching `ptr`, `ptr`+1, ... with wrap.
  - If a grant exists: `data_out` <= lane `grant`, `valid_out` <= 1, `lane_out` <= `grant`, `ptr` <= `grant`+1 with wrap.
  - If no lane is valid: `valid_out` <= 0; `data_out`, `lane_out` and `ptr` hold.
- No backpressure: the downstream side must accept one word per cycle.
- Inputs are sampled only on the edge; there is no storage in front of the mux, so a lane that is not served loses that cycle's word. Upstream must keep holding the word until it is served.

## Timing
- Latency: 1 cycle. Inputs sampled at edge t appear on the outputs after edge t.
- MODE 0: each lane is visited exactly once every N cycles. `frame_start` has period N.
- MODE 1 fairness: a lane that stays valid is served within N cycles.
- MODE 1 throughput: all lanes valid gives lanes 0,1,..,N-1,0,...; a single valid lane is served every cycle.
- Reset asserted (asynchronous): `ptr`=0, `data_out`=0, `valid_out`=0, `lane_out`=0, `frame_start`=0, all immediately. This also applies mid-stream; no partial state survives.
- First edge after reset deassertion: MODE 0 samples lane 0, so `frame_start` goes high on that output. MODE 1 searches starting at lane 0.
- `valid_in` changing in the same cycle as a grant: only the value sampled at the edge matters.

## Structure
- Shared package `phy_tx_pkg` holds the mode constants `MUX_MODE_TDM`=0 and `MUX_MODE_RR`=1, and the LW width function.
- One sub-module, `rr_pick`: combinational rotating-priority finder. Inputs are `req[N]` and `ptr`; outputs are `found` and `grant`. Implement it as double-width request masking, with no loops over variable bounds.
- Top-level contents: the pointer register, the output registers, the lane-slice mux, and a generate-selected mode path.

## Test plan
- N=4, WIDTH=8, MODE 0, all lanes valid with data 0xA0..0xA3:
  - Output is A0,A1,A2,A3,A0 starting 1 cycle after reset release.
  - `frame_start` is high on each A0; `lane_out` is 0,1,2,3,0.
- MODE 0, lane 2 invalid:
  - In the slot-2 cycle `valid_out`=0 and `data_out` holds 0xA1.
  - The next cycle outputs 0xA3.
- MODE 1, only lanes 1 and 3 valid (0x11, 0x33):
  - Output alternates 0x11,0x33 with `valid_out` continuously 1 and `lane_out` 1,3,1,3.
  - `frame_start`=0 throughout.
- MODE 1, no lanes valid for 3 cycles, then lane 0 valid:
  - During the idle cycles `valid_out`=0 and `data_out`/`lane_out` hold.
  - The first grant is lane 0, and the search then restarts from the pointer left by the last grant.
- Reset mid-stream (N=3, MODE 0, asserted between clock edges):
  - All outputs read 0 within the same cycle.
  - After release the sequence restarts at lane 0; confirm the pointer wraps 2->0 and never reaches 3.
- WIDTH=10, N=5, MODE 1, random `valid_in` for 10k cycles against a scoreboard model:
  - No lane starves for more than 5 cycles.
  - Every served word matches its sampled input.
